// File: rtl/t02_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The optional timeout feature is selected with T02_ARB_TIMEOUT_EN.
package t02_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam logic [31:0] T02_ARB_BAD_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  T02_ARB_FULL_SEL = 4'hF;

endpackage

// File: rtl/t02_mem_arbiter_timeout.sv
// Outstanding-transaction watchdog for the memory arbiter; this module only
// exists when T02_ARB_TIMEOUT_EN is defined.
`ifdef T02_ARB_TIMEOUT_EN
module t02_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    // Saturates at the limit so the expiry stays asserted until the FSM leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule
`endif

// File: rtl/t02_mem_arbiter.sv
// Round-robin arbiter sharing one wishbone manager between fetch and load/store.
// Define T02_ARB_TIMEOUT_EN to force-complete stuck transactions and raise err.
module t02_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic        i_ack,
    output logic [31:0] i_rdat,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdat,
    input  logic [3:0]  d_sel,
    output logic        d_ack,
    output logic [31:0] d_rdat,
    output logic [31:0] mgr_adr,
    output logic [31:0] mgr_wdat,
    output logic [3:0]  mgr_sel,
    output logic        mgr_ren,
    output logic        mgr_wen,
    input  logic [31:0] mgr_rdat,
    input  logic        mgr_busy,
    output logic        err
);

    import t02_arb_pkg::*;

    arb_state_t r_state;
    arb_owner_t r_last;
    arb_owner_t r_owner;
    logic       r_we;

    logic        w_grant_any;
    logic        w_grant_d;
    logic        w_expired;
    logic        w_finish_ok;
    logic        w_finish_bad;
    logic        w_capture;
    logic [31:0] w_cap_data;

    // A stale busy from the manager holds off any new grant.
    assign w_grant_any = (i_req || d_req) && !mgr_busy;
    assign w_grant_d   = d_req && (!i_req || (r_last == OWN_INSTR));

    assign w_finish_ok  = (r_state == ARB_WAIT) && !mgr_busy;
    assign w_finish_bad = ((r_state == ARB_ISSUE) || (r_state == ARB_WAIT))
                          && w_expired && !w_finish_ok;
    assign w_capture    = w_finish_bad || (w_finish_ok && !r_we);
    assign w_cap_data   = w_finish_bad ? T02_ARB_BAD_DATA : mgr_rdat;

`ifdef T02_ARB_TIMEOUT_EN
    logic w_cnt_clear;
    logic w_cnt_en;

    assign w_cnt_clear = (r_state == ARB_IDLE) && w_grant_any;
    assign w_cnt_en    = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT);

    t02_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_cnt_clear),
        .i_count_en(w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_finish_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign w_expired = 1'b0;
    // Without the watchdog err is a constant zero; the comparison is never true.
    assign err       = (TIMEOUT_CYCLES < 0);
`endif

    // Main sequencer: latch the winner's request, handshake, then ack for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_last   <= OWN_INSTR;
            r_owner  <= OWN_INSTR;
            r_we     <= 1'b0;
            mgr_adr  <= '0;
            mgr_wdat <= '0;
            mgr_sel  <= '0;
            mgr_ren  <= 1'b0;
            mgr_wen  <= 1'b0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (w_finish_ok || w_finish_bad) begin
                r_state <= ARB_DONE;
                mgr_ren <= 1'b0;
                mgr_wen <= 1'b0;
                i_ack   <= (r_owner == OWN_INSTR);
                d_ack   <= (r_owner == OWN_DATA);
            end else begin
                case (r_state)
                    ARB_IDLE: begin
                        if (w_grant_any) begin
                            r_state <= ARB_ISSUE;
                            if (w_grant_d) begin
                                r_owner  <= OWN_DATA;
                                r_we     <= d_we;
                                mgr_adr  <= d_adr;
                                mgr_wdat <= d_wdat;
                                mgr_sel  <= d_sel;
                                mgr_ren  <= !d_we;
                                mgr_wen  <= d_we;
                            end else begin
                                r_owner  <= OWN_INSTR;
                                r_we     <= 1'b0;
                                mgr_adr  <= i_adr;
                                mgr_wdat <= '0;
                                mgr_sel  <= T02_ARB_FULL_SEL;
                                mgr_ren  <= 1'b1;
                                mgr_wen  <= 1'b0;
                            end
                        end
                    end
                    ARB_ISSUE: begin
                        if (mgr_busy) begin
                            r_state <= ARB_WAIT;
                            mgr_ren <= 1'b0;
                            mgr_wen <= 1'b0;
                        end
                    end
                    ARB_WAIT: begin
                        r_state <= ARB_WAIT;
                    end
                    ARB_DONE: begin
                        r_last  <= r_owner;
                        r_state <= ARB_IDLE;
                    end
                    default: begin
                        r_state <= ARB_IDLE;
                    end
                endcase
            end
        end
    end

    // Writes leave the owner's read-data register untouched unless forced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdat <= '0;
            d_rdat <= '0;
        end else if (w_capture) begin
            if (r_owner == OWN_DATA) begin
                d_rdat <= w_cap_data;
            end else begin
                i_rdat <= w_cap_data;
            end
        end
    end

endmodule
